// File: rtl/bnn_pkg.sv
// Shared types and constants for the BNN output stage (bpu_act_pool and helpers).
package bnn_pkg;

  localparam int NUM_BPU = 8;   // channels per pass, one per BPU
  localparam int IN_W    = 7;   // width of one signed BPU partial sum
  localparam int ACC_W   = 12;  // accumulator / threshold width

  typedef logic signed [IN_W-1:0]  psum_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  // Saturation limits of the accumulator
  localparam acc_t ACC_MAX = acc_t'((1 << (ACC_W-1)) - 1);
  localparam acc_t ACC_MIN = acc_t'(-(1 << (ACC_W-1)));

  // Add a sign-extended partial sum to an accumulator, clamping instead of wrapping
  function automatic acc_t sat_add(input acc_t a, input psum_t b);
    logic signed [ACC_W:0] s;
    s = (ACC_W+1)'(a) + (ACC_W+1)'(b);
    if (s > (ACC_W+1)'(ACC_MAX))      return ACC_MAX;
    else if (s < (ACC_W+1)'(ACC_MIN)) return ACC_MIN;
    else                              return s[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/bpu_act_pool_if.sv
// Result stream toward the feature-map writeback: valid/ready with an 8-bit word.
interface bpu_act_pool_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/bnn_out_fifo.sv
// Two-entry, 8-bit FIFO. A push while full is only accepted when a pop happens
// in the same cycle; otherwise the word is ignored (the caller flags overflow).
module bnn_out_fifo (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  logic [7:0] mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       wr_en;
  logic       rd_en;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign rd_en   = pop && !empty;
  assign wr_en   = push && (!full || rd_en);
  assign rd_data = mem[rd_ptr];

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= !wr_ptr;
      end
      if (rd_en) rd_ptr <= !rd_ptr;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bpu_act_pool.sv
// Accumulates per-BPU popcount sums across passes, binarises each channel against
// its threshold, optionally 2x2 max-pools (macro BPU_ACT_POOL_EN) and queues the
// packed 8-bit result in a 2-entry output buffer.
module bpu_act_pool
  import bnn_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  psum_t [NUM_BPU-1:0]    bpu_out,
  input  logic                   acc_en,
  input  logic                   acc_clr,
  input  logic                   acc_last,
  input  logic                   thr_load,
  input  logic [2:0]             thr_sel,
  input  acc_t                   thr_data,
  bpu_act_pool_if.master         out_if,
  output logic                   stall,
  output logic                   overflow
);

  acc_t             acc  [NUM_BPU];
  acc_t             thr  [NUM_BPU];
  acc_t             fsum [NUM_BPU];
  logic [NUM_BPU-1:0] bits;
  logic             fire;
  logic             push;
  logic [7:0]       push_data;
  logic             pop;
  logic             full;
  logic             empty;
  logic [1:0]       count;

  assign fire = enable && acc_en && acc_last;

  // Saturated next sum per channel (acc_clr restarts from zero) and its sign bit
  always_comb begin
    for (int i = 0; i < NUM_BPU; i++) begin
      fsum[i] = sat_add(acc_clr ? acc_t'(0) : acc[i], $signed(bpu_out[i]));
      bits[i] = (fsum[i] >= thr[i]);
    end
  end

  // Accumulators: add, restart, clear, or auto-clear after the final pass
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_BPU; i++) acc[i] <= '0;
    end else if (enable) begin
      for (int i = 0; i < NUM_BPU; i++) begin
        if (acc_en)       acc[i] <= acc_last ? acc_t'(0) : fsum[i];
        else if (acc_clr) acc[i] <= '0;
      end
    end
  end

  // Threshold table; a write in the same cycle as acc_last is seen by the next word
  // NOTE: this small table is reset because the reset value (0) is architecturally visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_BPU; i++) thr[i] <= '0;
    end else if (enable && thr_load) begin
      thr[thr_sel] <= thr_data;
    end
  end

`ifdef BPU_ACT_POOL_EN
  logic [1:0] pool_cnt;
  logic [7:0] pool_bits;

  assign push      = fire && (pool_cnt == 2'd3);
  assign push_data = pool_bits | bits;

  // 2x2 max-pool of binary maps: OR four results, emit on the fourth
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pool_cnt  <= 2'd0;
      pool_bits <= '0;
    end else if (fire) begin
      if (pool_cnt == 2'd3) begin
        pool_cnt  <= 2'd0;
        pool_bits <= '0;
      end else begin
        pool_cnt  <= pool_cnt + 2'd1;
        pool_bits <= pool_bits | bits;
      end
    end
  end
`else
  assign push      = fire;
  assign push_data = bits;
`endif

  assign pop = out_if.out_valid && out_if.out_ready;

  bnn_out_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .rd_data   (out_if.out_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign out_if.out_valid = !empty;
  assign stall            = (count == 2'd2);

  // Sticky drop flag: a completed word arrived with no room and no pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     overflow <= 1'b0;
    else if (push && full && !pop) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_bpu_act_pool.sv
// Randomised and directed bench for bpu_act_pool against a behavioural model
// built from integer sums, a word queue and a sticky drop flag.
module tb_bpu_act_pool;
  import bnn_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b1;
  psum_t [NUM_BPU-1:0] bpu = '0;
  logic acc_en = 1'b0, acc_clr = 1'b0, acc_last = 1'b0, thr_load = 1'b0;
  logic [2:0] thr_sel = '0;
  acc_t thr_data = '0;
  logic stall, overflow;

  bpu_act_pool_if ifc ();

  bpu_act_pool dut (
    .clk(clk), .rst(rst), .enable(enable), .bpu_out(bpu),
    .acc_en(acc_en), .acc_clr(acc_clr), .acc_last(acc_last),
    .thr_load(thr_load), .thr_sel(thr_sel), .thr_data(thr_data),
    .out_if(ifc.master), .stall(stall), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int         m_acc [NUM_BPU];
  int         m_thr [NUM_BPU];
  logic [7:0] m_q [$];
  bit         m_ovf;
  int         m_pcnt;
  logic [7:0] m_pbits;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_BPU; i++) begin
      m_acc[i] = 0;
      m_thr[i] = 0;
    end
    m_q.delete();
    m_ovf   = 1'b0;
    m_pcnt  = 0;
    m_pbits = '0;
  endtask

  // One clock of the specified behaviour, using the inputs about to be sampled
  task automatic model_apply();
    bit         pop;
    bit         push;
    logic [7:0] b;
    logic [7:0] w;
    int         s;
    pop  = (m_q.size() != 0) && ifc.out_ready;
    push = 1'b0;
    b    = '0;
    w    = '0;
    if (enable) begin
      if (acc_en) begin
        for (int i = 0; i < NUM_BPU; i++) begin
          s = (acc_clr ? 0 : m_acc[i]) + int'($signed(bpu[i]));
          if (s > 2047)  s = 2047;
          if (s < -2048) s = -2048;
          b[i]     = (s >= m_thr[i]);
          m_acc[i] = acc_last ? 0 : s;
        end
      end else if (acc_clr) begin
        for (int i = 0; i < NUM_BPU; i++) m_acc[i] = 0;
      end
      if (acc_en && acc_last) begin
`ifdef BPU_ACT_POOL_EN
        m_pbits = m_pbits | b;
        m_pcnt++;
        if (m_pcnt == 4) begin
          push    = 1'b1;
          w       = m_pbits;
          m_pbits = '0;
          m_pcnt  = 0;
        end
`else
        push = 1'b1;
        w    = b;
`endif
      end
      if (thr_load) m_thr[thr_sel] = int'(thr_data);
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < 2) m_q.push_back(w);
      else                m_ovf = 1'b1;
    end
  endtask

  task automatic check_outputs();
    check("valid", ifc.out_valid, m_q.size() != 0);
    if (m_q.size() != 0) check("data", ifc.out_data, m_q[0]);
    check("stall", stall, m_q.size() == 2);
    check("overflow", overflow, m_ovf);
  endtask

  // Advance one clock: model and DUT consume the same inputs, then compare
  task automatic step();
    model_apply();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    enable   = 1'b1;
    acc_en   = 1'b0;
    acc_clr  = 1'b0;
    acc_last = 1'b0;
    thr_load = 1'b0;
    bpu      = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    ifc.out_ready = 1'b0;
    rst = 1'b0;
    model_reset();
    #2;
    check("rst_valid", ifc.out_valid, 1'b0);
    check("rst_data", ifc.out_data, 8'h00);
    check("rst_stall", stall, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
  endtask

  task automatic pass_all(input int v, input bit clr, input bit last);
    for (int i = 0; i < NUM_BPU; i++) bpu[i] = psum_t'(v);
    acc_en   = 1'b1;
    acc_clr  = clr;
    acc_last = last;
    step();
    idle_inputs();
  endtask

  task automatic load_thr(input int ch, input int v);
    thr_load = 1'b1;
    thr_sel  = 3'(ch);
    thr_data = acc_t'(v);
    step();
    idle_inputs();
  endtask

  task automatic drain();
    ifc.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    ifc.out_ready = 1'b0;
  endtask

  initial begin
    ifc.out_ready = 1'b0;
    do_reset();

`ifndef BPU_ACT_POOL_EN
    // Three passes of +5 against zero thresholds
    pass_all(5, 1'b1, 1'b0);
    pass_all(5, 1'b0, 1'b0);
    pass_all(5, 1'b0, 1'b1);
    check("t1_valid", ifc.out_valid, 1'b1);
    check("t1_data", ifc.out_data, 8'hFF);
    drain();

    // Per-channel thresholds, single pass of -1
    for (int c = 0; c < NUM_BPU; c++) load_thr(c, (c == 3) ? 20 : -1);
    pass_all(-1, 1'b1, 1'b1);
    check("t2_data", ifc.out_data, 8'hF7);
    drain();

    // Saturation on channel 0 against threshold 2047
    load_thr(0, 2047);
    for (int p = 0; p < 40; p++) begin
      bpu      = '0;
      bpu[0]   = psum_t'(63);
      acc_en   = 1'b1;
      acc_clr  = (p == 0);
      acc_last = (p == 39);
      step();
    end
    idle_inputs();
    check("t3_bit0", ifc.out_data[0], 1'b1);
    drain();

    // Full buffer with push and pop together: nothing dropped
    pass_all(1, 1'b1, 1'b1);
    pass_all(-3, 1'b1, 1'b1);
    check("t4_stall", stall, 1'b1);
    ifc.out_ready = 1'b1;
    pass_all(2, 1'b1, 1'b1);
    ifc.out_ready = 1'b0;
    check("t4_stall_after", stall, 1'b1);
    check("t4_overflow", overflow, 1'b0);
    drain();

    // Three words with no consumer: third dropped, first two kept in order
    pass_all(7, 1'b1, 1'b1);
    pass_all(-9, 1'b1, 1'b1);
    check("t5_stall", stall, 1'b1);
    pass_all(0, 1'b1, 1'b1);
    check("t5_overflow", overflow, 1'b1);
    drain();
`else
    // Pooling: channel-0 bits 0,0,1,0, all other channels 0
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NUM_BPU; i++) bpu[i] = psum_t'(-1);
      if (r == 2) bpu[0] = psum_t'(1);
      acc_en   = 1'b1;
      acc_clr  = 1'b1;
      acc_last = 1'b1;
      step();
      idle_inputs();
      if (r < 3) check("pool_no_out", ifc.out_valid, 1'b0);
    end
    check("pool_valid", ifc.out_valid, 1'b1);
    check("pool_data", ifc.out_data, 8'h01);
    drain();
`endif

    // Random traffic with a mid-run reset
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      enable   = ($urandom_range(0, 9) != 0);
      acc_en   = ($urandom_range(0, 1) == 1);
      acc_clr  = ($urandom_range(0, 4) == 0);
      acc_last = ($urandom_range(0, 3) == 0);
      thr_load = ($urandom_range(0, 4) == 0);
      thr_sel  = 3'($urandom_range(0, 7));
      thr_data = ($urandom_range(0, 7) == 0) ? acc_t'($urandom) :
                 acc_t'(int'($urandom_range(0, 400)) - 200);
      for (int i = 0; i < NUM_BPU; i++) bpu[i] = psum_t'(int'($urandom_range(0, 127)) - 64);
      ifc.out_ready = ($urandom_range(0, 9) < 6);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bpu_act_pool.md
# bpu_act_pool

Downstream stage of the BPU group: takes the eight signed per-BPU popcount sums each pass, accumulates them across passes into full-depth per-channel sums, binarises each sum against a per-channel threshold (folded batch-norm + sign), optionally 2x2 max-pools the binary maps, and packs the eight channel bits into one output byte. Results leave through a 2-entry buffer with a valid/ready handshake toward the feature-map writeback.

## Interface
- NUM_BPU, 8, channels per pass (one per BPU)
- IN_W, 7, width of each signed BPU sum
- ACC_W, 12, signed accumulator and threshold width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- enable  in  1  clock enable for the accumulate/threshold/pool path
- bpu_out  in  [NUM_BPU-1:0][IN_W-1:0] signed  per-channel partial sums
- acc_en  in  1  add bpu_out into the accumulators this cycle
- acc_clr  in  1  clear accumulators (start of new output pixel)
- acc_last  in  1  with acc_en: this is the final pass; binarise the result
- thr_load  in  1  write thr_data to threshold[thr_sel]
- thr_sel  in  3  threshold channel index
- thr_data  in  ACC_W signed  threshold value
- out_valid  out  1  out_data holds a result
- out_ready  in  1  consumer accepts out_data
- out_data  out  8  packed channel bits, bit i = channel i
- stall  out  1  buffer full; upstream must not issue acc_last
- overflow  out  1  sticky: a result was dropped

## Operation
- Accumulate: on enable & acc_en, acc[i] <= sat(acc[i] + sext(bpu_out[i])); saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1], never wrap.
- acc_clr & acc_en same cycle: acc[i] <= sext(bpu_out[i]) (fresh start). acc_clr alone: acc[i] <= 0.
- acc_last & acc_en: final sum s[i] = sat(acc[i] + sext(bpu_out[i])); bit[i] = (s[i] >= threshold[i]) signed compare. Accumulators then clear automatically. acc_last without acc_en is ignored.
- Threshold: thr_load writes threshold[thr_sel] when enable high; a write to the same channel in the same cycle as acc_last uses the old value.
- Buffer: 2-entry FIFO of 8-bit words. Push on a completed word, pop on out_valid & out_ready. Simultaneous push and pop when full: both happen, no drop.
- Full and push without pop: word dropped, overflow set; cleared only by reset.
- enable low: accumulators, thresholds and pool state hold; FIFO pop/handshake continues.

## Timing
- Accumulator visible one cycle after acc_en.
- Without pooling: word pushed at the acc_last edge; out_valid high the next cycle (1-cycle latency).
- stall = FIFO count == 2, combinational from registered count.
- out_data stable while out_valid & !out_ready.
- Reset values: acc 0, thresholds 0, FIFO empty, out_valid 0, out_data 0, stall 0, overflow 0, pool count 0, pool bits 0.
- Reset mid-operation discards partial sums, pool state and buffered words.

## Configuration
- BPU_ACT_POOL_EN defined: 2x2 max-pool. Binary max = OR. Pool register p[7:0] and 2-bit counter; each acc_last ORs bits into p, counter 0->1->2->3; on the 4th, (p|bit) is pushed, p and counter clear. stall asserts only while FIFO full; drop rule applies at the 4th result only. Latency from 4th acc_last to out_valid: 1 cycle.
- Not defined: every acc_last pushes its word directly; no pool register or counter.

## Structure
- Shared package bnn_pkg: NUM_BPU, IN_W, ACC_W, typedefs psum_t (signed IN_W), acc_t (signed ACC_W), and the saturation limits.
- One sub-module: bnn_out_fifo (2-entry, 8-bit, push/pop/full/empty/count).

## Test plan
- Reset then 3 passes of bpu_out all +5, thresholds 0 -> acc 15, out_data 8'hFF, out_valid one cycle after acc_last.
- Threshold ch3=20, ch0..2,4..7=-1, single pass bpu_out all -1 with acc_last -> out_data 8'hF7 (ch3 0, others 1 since -1 >= -1).
- 40 passes of +63 on ch0 -> acc saturates at 2047, no wrap; threshold 2047 -> bit0 = 1.
- out_ready held low, three acc_last words -> stall high after two, third dropped, overflow 1; later pops return first two words in order.
- Full FIFO with acc_last and out_ready same cycle -> no drop, count stays 2, overflow 0.
- BPU_ACT_POOL_EN: four acc_last with channel-0 bits 0,0,1,0 and others 0 -> single word 8'h01 after the 4th; no output after first three.
